// File: rtl/matmat_pkg.sv
// Shared types and helpers for the sequential matrix multiplier.
package matmat_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  // Wide enough that a full N-term dot product of unsigned W-bit elements never wraps.
  function automatic int acc_width(input int data_width, input int matrix_size);
    return 2 * data_width + $clog2(matrix_size);
  endfunction

  function automatic int elem_lsb(input int r, input int c, input int n, input int w);
    return (r * n + c) * w;
  endfunction

endpackage

// File: rtl/matmat_mac.sv
// Single multiply-accumulate lane with wrap/saturate reduction of the completed dot product.
module matmat_mac import matmat_pkg::*; #(
  parameter int DATA_WIDTH  = 8,
  parameter int MATRIX_SIZE = 4,
  parameter int SATURATE    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  en_i,
  input  logic                  last_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] res_o,
  output logic                  ovf_o
);

  localparam int ACC_W = acc_width(DATA_WIDTH, MATRIX_SIZE);

  logic [2*DATA_WIDTH-1:0] prod;
  logic [ACC_W-1:0]        sum;
  logic [ACC_W-1:0]        acc_q;
  logic [ACC_W-1:0]        acc_d;

  assign prod  = {{DATA_WIDTH{1'b0}}, a_i} * {{DATA_WIDTH{1'b0}}, b_i};
  assign sum   = acc_q + ACC_W'(prod);
  // res_o/ovf_o are only meaningful on the last term of a dot product.
  assign ovf_o = |sum[ACC_W-1:DATA_WIDTH];
  assign res_o = ((SATURATE != 0) && ovf_o) ? '1 : sum[DATA_WIDTH-1:0];

  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = last_i ? '0 : sum;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/matmat_seq.sv
// Sequential NxN matrix multiplier: one MAC per cycle, valid/ready on both sides.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high.
module matmat_seq import matmat_pkg::*; #(
  parameter int DATA_WIDTH  = 8,
  parameter int MATRIX_SIZE = 4,
  parameter int SATURATE    = 0
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            in_valid,
  output logic                                            in_ready,
  input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0]   matrix_a,
  input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0]   matrix_b,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0]   mul,
  output logic                                            overflow,
  output state_e                                          state_o
);

  localparam int N  = MATRIX_SIZE;
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_e        state_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          overflow_q;
  logic          ovf_q;
  logic [CW-1:0] row_q;
  logic [CW-1:0] col_q;
  logic [CW-1:0] k_q;

  logic [W-1:0] a_in  [N][N];
  logic [W-1:0] b_in  [N][N];
  logic [W-1:0] a_q   [N][N];
  logic [W-1:0] b_q   [N][N];
  logic [W-1:0] res_q [N][N];
  logic [W-1:0] mul_q [N][N];

  logic [W-1:0] mac_res;
  logic         mac_ovf;

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      assign a_in[r][c]                          = matrix_a[elem_lsb(r, c, N, W) +: W];
      assign b_in[r][c]                          = matrix_b[elem_lsb(r, c, N, W) +: W];
      assign mul[elem_lsb(r, c, N, W) +: W]      = mul_q[r][c];
    end
  end

  matmat_mac #(
    .DATA_WIDTH  (W),
    .MATRIX_SIZE (N),
    .SATURATE    (SATURATE)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .clear_i ((state_q == ST_IDLE) && in_valid),
    .en_i    (state_q == ST_COMPUTE),
    .last_i  (k_q == LAST),
    .a_i     (a_q[row_q][k_q]),
    .b_i     (b_q[k_q][col_q]),
    .res_o   (mac_res),
    .ovf_o   (mac_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      ovf_q       <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      k_q         <= '0;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          a_q[r][c]   <= '0;
          b_q[r][c]   <= '0;
          res_q[r][c] <= '0;
          mul_q[r][c] <= '0;
        end
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q        <= a_in;
            b_q        <= b_in;
            row_q      <= '0;
            col_q      <= '0;
            k_q        <= '0;
            ovf_q      <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= ST_COMPUTE;
          end
        end
        ST_COMPUTE: begin
          if (k_q != LAST) begin
            k_q <= k_q + 1'b1;
          end else begin
            k_q                 <= '0;
            res_q[row_q][col_q] <= mac_res;
            ovf_q               <= ovf_q | mac_ovf;
            if (col_q != LAST) begin
              col_q <= col_q + 1'b1;
            end else begin
              col_q <= '0;
              if (row_q != LAST) begin
                row_q <= row_q + 1'b1;
              end else begin
                // Final element bypasses res_q so the whole result lands in mul at once.
                row_q            <= '0;
                mul_q            <= res_q;
                mul_q[N-1][N-1]  <= mac_res;
                overflow_q       <= ovf_q | mac_ovf;
                out_valid_q      <= 1'b1;
                state_q          <= ST_DONE;
              end
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign overflow  = overflow_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_matmat_seq.sv
// Randomised and directed bench for matmat_seq with queue-based scoreboards per instance.
module tb_matmat_seq;
  import matmat_pkg::*;

  logic clk;
  logic rst;

  // Main instance: N=4, W=8, wrap mode.
  logic         in_valid, in_ready, out_valid, out_ready, overflow;
  logic [127:0] ma, mb, mul4;
  state_e       st4;

  // Two N=2 instances sharing stimulus: wrap and saturate.
  logic         s_valid, s_ordy;
  logic         s_irdy0, s_irdy1, s_ovalid0, s_ovalid1, s_ovf0, s_ovf1;
  logic [31:0]  sa, sb, smul0, smul1;
  state_e       st2a, st2b;

  logic [128:0] exp_q[$];
  logic [32:0]  exp2_q[$];
  logic [32:0]  exp2s_q[$];

  int  errors = 0;
  int  checks = 0;
  bit  rand_rdy = 0;

  matmat_seq #(.DATA_WIDTH(8), .MATRIX_SIZE(4), .SATURATE(0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .matrix_a(ma), .matrix_b(mb), .out_valid(out_valid), .out_ready(out_ready),
    .mul(mul4), .overflow(overflow), .state_o(st4)
  );

  matmat_seq #(.DATA_WIDTH(8), .MATRIX_SIZE(2), .SATURATE(0)) u_dut2w (
    .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(s_irdy0),
    .matrix_a(sa), .matrix_b(sb), .out_valid(s_ovalid0), .out_ready(s_ordy),
    .mul(smul0), .overflow(s_ovf0), .state_o(st2a)
  );

  matmat_seq #(.DATA_WIDTH(8), .MATRIX_SIZE(2), .SATURATE(1)) u_dut2s (
    .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(s_irdy1),
    .matrix_a(sa), .matrix_b(sb), .out_valid(s_ovalid1), .out_ready(s_ordy),
    .mul(smul1), .overflow(s_ovf1), .state_o(st2b)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [128:0] ref_mul(input logic [127:0] a, input logic [127:0] b,
                                           input int n, input bit sat);
    logic [127:0] m;
    bit           ovf;
    int           s;
    m   = '0;
    ovf = 1'b0;
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < n; c++) begin
        s = 0;
        for (int k = 0; k < n; k++)
          s += int'(a[(r*n+k)*8 +: 8]) * int'(b[(k*n+c)*8 +: 8]);
        if (s > 255) begin
          ovf = 1'b1;
          s   = sat ? 255 : s % 256;
        end
        m[(r*n+c)*8 +: 8] = 8'(s);
      end
    end
    return {ovf, m};
  endfunction

  function automatic logic [32:0] ref_mul2(input logic [31:0] a, input logic [31:0] b, input bit sat);
    logic [128:0] r;
    r = ref_mul({96'd0, a}, {96'd0, b}, 2, sat);
    return {r[128], r[31:0]};
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout/unexpected expected event", name);
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        fail_now("n4_unexpected_result");
      end else begin
        chk("n4_mul", mul4, exp_q[0][127:0]);
        chk("n4_overflow", {127'd0, overflow}, {127'd0, exp_q[0][128]});
        chk("n4_in_ready_in_done", {127'd0, in_ready}, 128'd0);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && s_ovalid0) begin
      if (exp2_q.size() == 0) begin
        fail_now("n2w_unexpected_result");
      end else begin
        chk("n2w_mul", {96'd0, smul0}, {96'd0, exp2_q[0][31:0]});
        chk("n2w_overflow", {127'd0, s_ovf0}, {127'd0, exp2_q[0][32]});
        if (s_ordy) void'(exp2_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && s_ovalid1) begin
      if (exp2s_q.size() == 0) begin
        fail_now("n2s_unexpected_result");
      end else begin
        chk("n2s_mul", {96'd0, smul1}, {96'd0, exp2s_q[0][31:0]});
        chk("n2s_overflow", {127'd0, s_ovf1}, {127'd0, exp2s_q[0][32]});
        if (s_ordy) void'(exp2s_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  function automatic logic [127:0] rand_mat(input int maxv);
    logic [127:0] m;
    for (int i = 0; i < 16; i++) m[i*8 +: 8] = 8'($urandom_range(0, maxv));
    return m;
  endfunction

  task automatic send4(input logic [127:0] a, input logic [127:0] b);
    int g = 0;
    while (!in_ready && g < 1000) begin
      cycle();
      g++;
    end
    if (!in_ready) begin
      fail_now("n4_in_ready_wait");
      return;
    end
    ma = a;
    mb = b;
    in_valid = 1'b1;
    exp_q.push_back(ref_mul(a, b, 4, 1'b0));
    cycle();
    in_valid = 1'b0;
    ma = {$urandom, $urandom, $urandom, $urandom};
    mb = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic send2(input logic [31:0] a, input logic [31:0] b);
    int g = 0;
    while (!(s_irdy0 && s_irdy1) && g < 200) begin
      cycle();
      g++;
    end
    if (!(s_irdy0 && s_irdy1)) begin
      fail_now("n2_in_ready_wait");
      return;
    end
    sa = a;
    sb = b;
    s_valid = 1'b1;
    exp2_q.push_back(ref_mul2(a, b, 1'b0));
    exp2s_q.push_back(ref_mul2(a, b, 1'b1));
    cycle();
    s_valid = 1'b0;
    sa = $urandom;
    sb = $urandom;
  endtask

  task automatic wait_drain(input string name);
    int g = 0;
    while ((exp_q.size() != 0 || exp2_q.size() != 0 || exp2s_q.size() != 0) && g < 3000) begin
      cycle();
      g++;
    end
    if (exp_q.size() != 0 || exp2_q.size() != 0 || exp2s_q.size() != 0) fail_now(name);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] a, b;
    int g;

    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; ma = '0; mb = '0;
    s_valid = 1'b0; s_ordy = 1'b1; sa = '0; sb = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", {127'd0, in_ready}, 128'd1);
    chk("reset_out_valid", {127'd0, out_valid}, 128'd0);
    chk("reset_mul", mul4, 128'd0);
    chk("reset_overflow", {127'd0, overflow}, 128'd0);
    chk("reset_n2_in_ready", {126'd0, s_irdy0, s_irdy1}, 128'd3);
    rst = 1'b0;
    cycle();

    // Directed 2x2 product and exact latency.
    send2(32'h04030201, 32'h08070605);
    for (int j = 1; j <= 8; j++) begin
      cycle();
      if (j == 7) chk("latency_not_early", {127'd0, s_ovalid0}, 128'd0);
      if (j == 8) begin
        chk("latency_exact", {127'd0, s_ovalid0}, 128'd1);
        chk("directed_mul", {96'd0, smul0}, {96'd0, 32'h322B1613});
        chk("directed_overflow", {127'd0, s_ovf0}, 128'd0);
      end
    end
    wait_drain("drain_directed");

    // Overflow in both output modes: every full sum is 800.
    send2(32'hC8C8C8C8, 32'h02020202);
    wait_drain("drain_overflow");
    chk("ovf_wrap_mul", {96'd0, smul0}, {96'd0, 32'h20202020});
    chk("ovf_wrap_flag", {127'd0, s_ovf0}, 128'd1);
    chk("ovf_sat_mul", {96'd0, smul1}, {96'd0, 32'hFFFFFFFF});
    chk("ovf_sat_flag", {127'd0, s_ovf1}, 128'd1);

    // Identity on the 4x4 instance.
    a = '0;
    for (int i = 0; i < 4; i++) a[(i*4+i)*8 +: 8] = 8'd1;
    b = rand_mat(255);
    send4(a, b);
    wait_drain("drain_identity");
    chk("identity_mul", mul4, b);
    chk("identity_overflow", {127'd0, overflow}, 128'd0);

    // Backpressure: hold the result for 20 cycles, try a stray accept.
    out_ready = 1'b0;
    send4(rand_mat(255), rand_mat(255));
    g = 0;
    while (!out_valid && g < 200) begin
      cycle();
      g++;
    end
    if (!out_valid) fail_now("bp_out_valid_wait");
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (i == 5) begin
        ma = rand_mat(255);
        mb = rand_mat(255);
        in_valid = 1'b1;
      end
      if (i == 6) in_valid = 1'b0;
    end
    out_ready = 1'b1;
    cycle();
    chk("bp_in_ready_after", {127'd0, in_ready}, 128'd1);
    chk("bp_out_valid_after", {127'd0, out_valid}, 128'd0);

    // Reset three cycles into COMPUTE, then a clean operation.
    send4(rand_mat(255), rand_mat(255));
    repeat (3) cycle();
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("midrst_mul", mul4, 128'd0);
    chk("midrst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("midrst_overflow", {127'd0, overflow}, 128'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    cycle();
    send4(rand_mat(255), rand_mat(255));
    wait_drain("drain_after_reset");

    // Randomised operands 0..9 with random output stalls.
    rand_rdy = 1'b1;
    for (int n = 0; n < 500; n++) send4(rand_mat(9), rand_mat(9));
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    wait_drain("drain_random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
